dtpu_wm_loader: RTL and testbench

DTPU_WM_LOADER -- requirements
Module: dtpu_wm_loader

---
 rtl/dtpu_pkg.sv | 20 ++
 rtl/dtpu_wm_loader.sv | 119 +++++++++++
 tb/tb_dtpu_wm_loader.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dtpu_pkg.sv
// Shared definitions for the DTPU weight-memory loader: FSM states, error codes
// and default widths.
package dtpu_pkg;

  localparam int DTPU_DATA_W = 64;
  localparam int DTPU_ADDR_W = 10;
  localparam int DTPU_LEN_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wm_state_e;

  localparam logic [1:0] ERR_NONE       = 2'b00;
  localparam logic [1:0] ERR_EARLY_LAST = 2'b01;
  localparam logic [1:0] ERR_NO_LAST    = 2'b10;

endpackage

// File: rtl/dtpu_wm_loader.sv
// Streams AXI-Stream weight beats into a linear region of weight memory,
// checking the beat count against tlast and reporting a sticky error code.
module dtpu_wm_loader
  import dtpu_pkg::*;
#(
  parameter int DATA_W = DTPU_DATA_W,
  parameter int ADDR_W = DTPU_ADDR_W,
  parameter int LEN_W  = DTPU_LEN_W
) (
  input  logic                axi_aclk,
  input  logic                s_axi_aresetn,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [LEN_W-1:0]    length,
  input  logic [DATA_W-1:0]   S_AXIS_wm_tdata,
  input  logic [DATA_W/8-1:0] S_AXIS_wm_tkeep,
  input  logic                S_AXIS_wm_tlast,
  input  logic                S_AXIS_wm_tvalid,
  output logic                S_AXIS_wm_tready,
  output logic                wm_we,
  output logic [ADDR_W-1:0]   wm_addr,
  output logic [DATA_W-1:0]   wm_wdata,
  output logic [DATA_W/8-1:0] wm_be,
  output logic                busy,
  output logic                done,
  output logic [1:0]          err,
  output logic [LEN_W-1:0]    beat_cnt
);

  wm_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        err_q, err_d;

  logic             accept;
  logic [LEN_W-1:0] cnt_inc;

  always_ff @(posedge axi_aclk) begin
    if (!s_axi_aresetn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // tready depends only on the registered state, never on tvalid.
  assign S_AXIS_wm_tready = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign accept           = S_AXIS_wm_tvalid && S_AXIS_wm_tready;
  assign cnt_inc          = cnt_q + LEN_W'(1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    wm_we   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          len_d   = length;
          cnt_d   = '0;
          err_d   = ERR_NONE;
          state_d = (length != '0) ? ST_LOAD : ST_DONE;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          wm_we  = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_inc;
          if (cnt_inc == len_q) begin
            if (S_AXIS_wm_tlast) begin
              state_d = ST_DONE;
            end else begin
              err_d   = ERR_NO_LAST;
              state_d = ST_DRAIN;
            end
          end else if (S_AXIS_wm_tlast) begin
            // Short packet: the final beat is still written before aborting.
            err_d   = ERR_EARLY_LAST;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        if (accept && S_AXIS_wm_tlast) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign wm_addr  = addr_q;
  assign wm_wdata = S_AXIS_wm_tdata;
  assign wm_be    = S_AXIS_wm_tkeep;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign err      = err_q;
  assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_dtpu_wm_loader.sv
// Directed bench for dtpu_wm_loader: a per-cycle vector table plus hand-written
// sequences for address wrap with bubbles and mid-load reset.
module tb_dtpu_wm_loader;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [9:0]  base_addr;
  logic [15:0] length;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        tready;
  logic        wm_we;
  logic [9:0]  wm_addr;
  logic [63:0] wm_wdata;
  logic [7:0]  wm_be;
  logic        busy;
  logic        done;
  logic [1:0]  err;
  logic [15:0] beat_cnt;

  int total = 0;
  int bad   = 0;

  dtpu_wm_loader dut (
    .axi_aclk         (clk),
    .s_axi_aresetn    (rstn),
    .start            (start),
    .base_addr        (base_addr),
    .length           (length),
    .S_AXIS_wm_tdata  (tdata),
    .S_AXIS_wm_tkeep  (tkeep),
    .S_AXIS_wm_tlast  (tlast),
    .S_AXIS_wm_tvalid (tvalid),
    .S_AXIS_wm_tready (tready),
    .wm_we            (wm_we),
    .wm_addr          (wm_addr),
    .wm_wdata         (wm_wdata),
    .wm_be            (wm_be),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .beat_cnt         (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [9:0]  base;
    logic [15:0] len;
    logic        tvalid;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        e_we;
    logic [9:0]  e_addr;
    logic        e_busy;
    logic        e_done;
    logic        e_tready;
    logic [1:0]  e_err;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic st, input logic [9:0] b, input logic [15:0] l,
                     input logic tv, input logic [63:0] td, input logic [7:0] tk,
                     input logic tl, input logic we, input logic [9:0] ad,
                     input logic bz, input logic dn, input logic tr,
                     input logic [1:0] er, input logic [15:0] cn);
    vec_t v;
    v.start = st; v.base = b; v.len = l; v.tvalid = tv; v.tdata = td;
    v.tkeep = tk; v.tlast = tl; v.e_we = we; v.e_addr = ad; v.e_busy = bz;
    v.e_done = dn; v.e_tready = tr; v.e_err = er; v.e_cnt = cn;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    start = 1'b0; base_addr = '0; length = '0;
    tvalid = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0;
  endtask

  initial begin
    logic [9:0] wrap_addr [4];
    int sent;
    int cyc;

    rstn = 1'b0;
    idle_inputs();
    tvalid = 1'b1;

    // Reset state, with tvalid held high to show tready/wm_we stay low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", beat_cnt, 0);
    chk("rst_tready", tready, 0);
    chk("rst_we", wm_we, 0);
    chk("rst_addr", wm_addr, 0);
    $display("reset checked");
    rstn = 1'b1;
    tvalid = 1'b0;

    // Normal load: base 0x010, len 4.
    add(1, 10'h010, 4, 0, 64'h0, 8'h00, 0,  0, 10'h000, 0, 0, 0, 2'b00, 0);
    add(0, 0, 0, 1, 64'hA1, 8'hFF, 0,       1, 10'h010, 1, 0, 1, 2'b00, 0);
    add(0, 0, 0, 1, 64'hA2, 8'h0F, 0,       1, 10'h011, 1, 0, 1, 2'b00, 1);
    add(0, 0, 0, 1, 64'hA3, 8'hF0, 0,       1, 10'h012, 1, 0, 1, 2'b00, 2);
    add(0, 0, 0, 1, 64'hA4, 8'h81, 1,       1, 10'h013, 1, 0, 1, 2'b00, 3);
    add(0, 0, 0, 0, 64'h0, 8'h00, 0,        0, 10'h000, 1, 1, 0, 2'b00, 4);
    add(0, 0, 0, 0, 64'h0, 8'h00, 0,        0, 10'h000, 0, 0, 0, 2'b00, 4);
    // Early tlast: len 4, tlast on beat 2.
    add(1, 10'h020, 4, 0, 64'h0, 8'h00, 0,  0, 10'h000, 0, 0, 0, 2'b00, 4);
    add(0, 0, 0, 1, 64'hB1, 8'h33, 0,       1, 10'h020, 1, 0, 1, 2'b00, 0);
    add(0, 0, 0, 1, 64'hB2, 8'h55, 1,       1, 10'h021, 1, 0, 1, 2'b00, 1);
    add(0, 0, 0, 0, 64'h0, 8'h00, 0,        0, 10'h000, 0, 0, 0, 2'b01, 2);
    // Missing tlast: len 2, 5 beats, last on beat 5.
    add(1, 10'h030, 2, 0, 64'h0, 8'h00, 0,  0, 10'h000, 0, 0, 0, 2'b01, 2);
    add(0, 0, 0, 1, 64'hC1, 8'h01, 0,       1, 10'h030, 1, 0, 1, 2'b00, 0);
    add(0, 0, 0, 1, 64'hC2, 8'h02, 0,       1, 10'h031, 1, 0, 1, 2'b00, 1);
    add(0, 0, 0, 1, 64'hC3, 8'h04, 0,       0, 10'h000, 1, 0, 1, 2'b10, 2);
    add(0, 0, 0, 1, 64'hC4, 8'h08, 0,       0, 10'h000, 1, 0, 1, 2'b10, 2);
    add(0, 0, 0, 1, 64'hC5, 8'h10, 1,       0, 10'h000, 1, 0, 1, 2'b10, 2);
    add(0, 0, 0, 0, 64'h0, 8'h00, 0,        0, 10'h000, 0, 0, 0, 2'b10, 2);
    // Zero-length start, then a start during LOAD that must be ignored.
    add(1, 10'h0F0, 0, 0, 64'h0, 8'h00, 0,  0, 10'h000, 0, 0, 0, 2'b10, 2);
    add(0, 0, 0, 0, 64'h0, 8'h00, 0,        0, 10'h000, 1, 1, 0, 2'b00, 0);
    add(0, 0, 0, 0, 64'h0, 8'h00, 0,        0, 10'h000, 0, 0, 0, 2'b00, 0);
    add(1, 10'h040, 2, 0, 64'h0, 8'h00, 0,  0, 10'h000, 0, 0, 0, 2'b00, 0);
    add(1, 10'h100, 7, 1, 64'hD1, 8'hC3, 0, 1, 10'h040, 1, 0, 1, 2'b00, 0);
    add(0, 0, 0, 1, 64'hD2, 8'h3C, 1,       1, 10'h041, 1, 0, 1, 2'b00, 1);
    add(0, 0, 0, 0, 64'h0, 8'h00, 0,        0, 10'h000, 1, 1, 0, 2'b00, 2);
    add(0, 0, 0, 0, 64'h0, 8'h00, 0,        0, 10'h000, 0, 0, 0, 2'b00, 2);

    foreach (vecs[i]) begin
      @(negedge clk);
      start = vecs[i].start; base_addr = vecs[i].base; length = vecs[i].len;
      tvalid = vecs[i].tvalid; tdata = vecs[i].tdata; tkeep = vecs[i].tkeep;
      tlast = vecs[i].tlast;
      #1;
      chk($sformatf("v%0d_we", i), wm_we, vecs[i].e_we);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("v%0d_done", i), done, vecs[i].e_done);
      chk($sformatf("v%0d_tready", i), tready, vecs[i].e_tready);
      chk($sformatf("v%0d_err", i), err, vecs[i].e_err);
      chk($sformatf("v%0d_cnt", i), beat_cnt, vecs[i].e_cnt);
      if (vecs[i].e_we) begin
        chk($sformatf("v%0d_addr", i), wm_addr, vecs[i].e_addr);
        chk($sformatf("v%0d_wdata", i), wm_wdata, vecs[i].tdata);
        chk($sformatf("v%0d_be", i), wm_be, vecs[i].tkeep);
      end
      $display("vec %0d applied: we=%0b addr=%0h busy=%0b done=%0b err=%0b cnt=%0d",
               i, wm_we, wm_addr, busy, done, err, beat_cnt);
    end

    // Address wrap with random tvalid bubbles: base 0x3FE, len 4.
    wrap_addr[0] = 10'h3FE; wrap_addr[1] = 10'h3FF;
    wrap_addr[2] = 10'h000; wrap_addr[3] = 10'h001;
    @(negedge clk);
    idle_inputs();
    start = 1'b1; base_addr = 10'h3FE; length = 16'd4;
    sent = 0;
    cyc = 0;
    while (sent < 4 && cyc < 60) begin
      @(negedge clk);
      idle_inputs();
      tvalid = 1'($urandom_range(0, 1));
      tdata = 64'hE0 + 64'(sent);
      tkeep = 8'hFF;
      tlast = (sent == 3);
      #1;
      chk("wrap_we", wm_we, tvalid);
      if (tvalid) begin
        chk("wrap_addr", wm_addr, wrap_addr[sent]);
        $display("wrap beat %0d written at %0h", sent, wm_addr);
        sent++;
      end
      cyc++;
    end
    chk("wrap_in_budget", sent, 4);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("wrap_done", done, 1);
    chk("wrap_err", err, 0);
    chk("wrap_cnt", beat_cnt, 4);

    // Reset after beat 2 of a len-8 load.
    @(negedge clk);
    start = 1'b1; base_addr = 10'h050; length = 16'd8;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      idle_inputs();
      tvalid = 1'b1; tdata = 64'hF0 + 64'(b); tkeep = 8'hFF;
      #1;
      chk("mid_we", wm_we, 1);
      chk("mid_addr", wm_addr, 10'h050 + 10'(b));
    end
    @(negedge clk);
    rstn = 1'b0;
    tvalid = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_tready", tready, 0);
    chk("mid_rst_we", wm_we, 0);
    chk("mid_rst_cnt", beat_cnt, 0);
    rstn = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_we", wm_we, 0);
    chk("post_rst_busy", busy, 0);
    $display("mid-load reset checked");

    // Fresh single-beat load after reset.
    @(negedge clk);
    idle_inputs();
    start = 1'b1; base_addr = 10'h060; length = 16'd1;
    @(negedge clk);
    idle_inputs();
    tvalid = 1'b1; tdata = 64'h1234; tkeep = 8'h0F; tlast = 1'b1;
    #1;
    chk("fresh_we", wm_we, 1);
    chk("fresh_addr", wm_addr, 10'h060);
    chk("fresh_be", wm_be, 8'h0F);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("fresh_done", done, 1);
    chk("fresh_cnt", beat_cnt, 1);
    chk("fresh_err", err, 0);
    $display("fresh load checked");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
